// File: rtl/rep_umul_pkg.sv
// Shared types and sizing helpers for the repeat-based unary multiplier.
package rep_umul_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} umulStateT;

  typedef enum logic {ModeUnipolar, ModeBipolar} umulModeT;

  // Counters must hold the full-scale value 2^winLog, hence one extra bit.
  function automatic int unsigned cntWidth(input int unsigned winLog);
    return winLog + 1;
  endfunction

endpackage

// File: rtl/sobolrng.sv
// One-dimensional Sobol sequence generator (Gray-code ordering, bit-reversed directions).
// Any 2^BITWIDTH consecutive outputs from a cleared state form a permutation of 0..2^BITWIDTH-1.
module sobolrng #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  output logic [BITWIDTH-1:0] sobolseq
);

  logic [BITWIDTH-1:0] cntQ;
  logic [BITWIDTH-1:0] dirVec;

  // Direction vector selected by the lowest zero bit of the step counter.
  // An all-ones counter selects the LSB so the sequence wraps back to zero.
  always_comb begin
    dirVec = '0;
    dirVec[0] = 1'b1;
    for (int i = int'(BITWIDTH) - 1; i >= 0; i--) begin
      if (!cntQ[i]) begin
        dirVec = '0;
        dirVec[BITWIDTH-1-i] = 1'b1;
      end
    end
  end

  // Step counter and sequence register; clear has priority over enable.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cntQ     <= '0;
      sobolseq <= '0;
    end else if (iClr) begin
      cntQ     <= '0;
      sobolseq <= '0;
    end else if (iEn) begin
      cntQ     <= cntQ + 1'b1;
      sobolseq <= sobolseq ^ dirVec;
    end
  end

endmodule

// File: rtl/rep_umul_nch.sv
// NCH-channel repeat-based unary multiplier with a shared counting window.
// Each channel compares its B register against a private Sobol stream and counts product ones
// over 2^WINLOG samples; the count is published with a one-cycle oValid pulse.
module rep_umul_nch
  import rep_umul_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned NCH      = 4,
  parameter int unsigned WINLOG   = 8
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iClr,
  input  logic                      iStart,
  input  logic                      iBipolar,
  input  logic [NCH-1:0]            A,
  input  logic [NCH*BITWIDTH-1:0]   B,
  input  logic [NCH-1:0]            loadB,
  output logic [NCH-1:0]            oB,
  output logic [NCH-1:0]            mult,
  output logic [NCH*(WINLOG+1)-1:0] oCnt,
  output logic                      oValid,
  output logic                      oBusy
);

  localparam int unsigned CntW = cntWidth(WINLOG);
  localparam logic [CntW-1:0] WinLast = CntW'((1 << WINLOG) - 1);

  umulStateT             stateQ, stateD;
  umulModeT              modeQ;
  logic [CntW-1:0]       winQ;
  logic [CntW-1:0]       accQ  [NCH];
  logic [BITWIDTH-1:0]   bRegQ [NCH];
  logic [BITWIDTH-1:0]   seq   [NCH];
  logic [NCH*CntW-1:0]   cntQ;
  logic                  validQ;
  logic [NCH-1:0]        rngEn;
  logic                  startAcc;
  logic                  rngClr;

  assign startAcc = (stateQ == StIdle) && iStart && !iClr;
  assign rngClr   = iClr || startAcc;
  assign oBusy    = (stateQ == StRun);
  assign oValid   = validQ;
  assign oCnt     = cntQ;

  // Per-channel comparator, product gate and RNG enable.
  always_comb begin
    oB    = '0;
    mult  = '0;
    rngEn = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      oB[i]    = (bRegQ[i] > seq[i]);
      mult[i]  = (modeQ == ModeBipolar) ? ~(A[i] ^ oB[i]) : (A[i] & oB[i]);
      rngEn[i] = (stateQ == StRun) && ((modeQ == ModeBipolar) || A[i]);
    end
  end

  // Next-state logic; iClr overrides every transition.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (iStart) stateD = StRun;
      StRun:   if (winQ == WinLast) stateD = StDone;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
    if (iClr) stateD = StIdle;
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) stateQ <= StIdle;
    else        stateQ <= stateD;
  end

  // Window counter, accumulators, mode latch and published count.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      modeQ  <= ModeUnipolar;
      winQ   <= '0;
      cntQ   <= '0;
      validQ <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) accQ[i] <= '0;
    end else if (iClr) begin
      winQ   <= '0;
      validQ <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) accQ[i] <= '0;
    end else begin
      validQ <= 1'b0;
      unique case (stateQ)
        StIdle: begin
          if (iStart) begin
            modeQ <= iBipolar ? ModeBipolar : ModeUnipolar;
            winQ  <= '0;
            for (int i = 0; i < int'(NCH); i++) accQ[i] <= '0;
          end
        end
        StRun: begin
          winQ <= winQ + 1'b1;
          for (int i = 0; i < int'(NCH); i++) accQ[i] <= accQ[i] + CntW'(mult[i]);
        end
        StDone: begin
          validQ <= 1'b1;
          for (int i = 0; i < int'(NCH); i++) cntQ[i*CntW +: CntW] <= accQ[i];
        end
        default: ;
      endcase
    end
  end

  // Operand registers; frozen while a window is running and kept across iClr.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < int'(NCH); i++) bRegQ[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (loadB[i] && (stateQ != StRun)) bRegQ[i] <= B[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  for (genvar i = 0; i < int'(NCH); i++) begin : genCh
    sobolrng #(
      .BITWIDTH (BITWIDTH)
    ) uRng (
      .iClk     (iClk),
      .iRstN    (iRstN),
      .iEn      (rngEn[i]),
      .iClr     (rngClr),
      .sobolseq (seq[i])
    );
  end

endmodule

// File: tb/tb_rep_umul_nch.sv
// Directed bench for rep_umul_nch (BITWIDTH=8, NCH=4, WINLOG=8).
module tb_rep_umul_nch;

  localparam int BW = 8;
  localparam int NC = 4;
  localparam int WL = 8;
  localparam int CW = WL + 1;

  logic              iClk;
  logic              iRstN;
  logic              iClr;
  logic              iStart;
  logic              iBipolar;
  logic [NC-1:0]     A;
  logic [NC*BW-1:0]  B;
  logic [NC-1:0]     loadB;
  logic [NC-1:0]     oB;
  logic [NC-1:0]     mult;
  logic [NC*CW-1:0]  oCnt;
  logic              oValid;
  logic              oBusy;

  int nChecks = 0;
  int nFails  = 0;

  rep_umul_nch #(
    .BITWIDTH (BW),
    .NCH      (NC),
    .WINLOG   (WL)
  ) dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iClr     (iClr),
    .iStart   (iStart),
    .iBipolar (iBipolar),
    .A        (A),
    .B        (B),
    .loadB    (loadB),
    .oB       (oB),
    .mult     (mult),
    .oCnt     (oCnt),
    .oValid   (oValid),
    .oBusy    (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [CW-1:0] cntOf(input int ch);
    return oCnt[ch*CW +: CW];
  endfunction

  // Reference Sobol value: bit-reversed Gray code of the index.
  function automatic logic [7:0] sob(input int n);
    logic [7:0] g;
    logic [7:0] r;
    g = 8'(n ^ (n >> 1));
    for (int i = 0; i < 8; i++) r[i] = g[7-i];
    return r;
  endfunction

  task automatic loadAll(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    B     = {b3, b2, b1, b0};
    loadB = '1;
    step();
    loadB = '0;
  endtask

  // Starts a window and waits (bounded) for oValid; lat is -1 on timeout.
  // obHigh reports whether every oB bit stayed high through RUN.
  task automatic runWindow(input bit sobA, input bit loadMid, output int lat, output bit obHigh);
    lat    = -1;
    obHigh = 1'b1;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (sobA) A = ((c <= 256) && (sob(c - 1) < 8'd128)) ? '1 : '0;
      if (loadMid && c == 50) begin
        B     = {4{8'd200}};
        loadB = '1;
      end else begin
        loadB = '0;
      end
      if (oBusy && !(&oB)) obHigh = 1'b0;
      step();
      if (oValid) begin
        lat = c;
        break;
      end
    end
    loadB = '0;
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    A     = '1;
    repeat (2) step();
    nChecks++; if (oCnt !== '0) begin nFails++; $display("FAIL reset_cnt got=%h exp=0", oCnt); end
    nChecks++; if (oValid !== 1'b0) begin nFails++; $display("FAIL reset_valid got=%b exp=0", oValid); end
    nChecks++; if (oBusy !== 1'b0) begin nFails++; $display("FAIL reset_busy got=%b exp=0", oBusy); end
    nChecks++; if (oB !== '0 || mult !== '0) begin nFails++; $display("FAIL reset_streams oB=%b mult=%b exp=0", oB, mult); end
    iRstN = 1'b1;
    step();
  endtask

  task automatic test_unipolar_full();
    int lat;
    bit obh;
    logic [CW-1:0] exp [4] = '{9'd0, 9'd1, 9'd128, 9'd255};
    iBipolar = 1'b0;
    A = '1;
    loadAll(8'd0, 8'd1, 8'd128, 8'd255);
    runWindow(1'b0, 1'b0, lat, obh);
    nChecks++; if (lat !== 257) begin nFails++; $display("FAIL uni_latency got=%0d exp=257", lat); end
    for (int i = 0; i < NC; i++) begin
      nChecks++;
      if (cntOf(i) !== exp[i]) begin nFails++; $display("FAIL uni_full ch%0d got=%0d exp=%0d", i, cntOf(i), exp[i]); end
    end
    step();
    nChecks++; if (oValid !== 1'b0 || oBusy !== 1'b0) begin nFails++; $display("FAIL uni_pulse valid=%b busy=%b exp=0/0", oValid, oBusy); end
  endtask

  task automatic test_unipolar_zero_a();
    int lat;
    bit obh;
    iBipolar = 1'b0;
    A = '0;
    loadAll(8'd200, 8'd1, 8'd1, 8'd1);
    runWindow(1'b0, 1'b0, lat, obh);
    nChecks++; if (lat !== 257) begin nFails++; $display("FAIL zeroa_latency got=%0d exp=257", lat); end
    nChecks++; if (oCnt !== '0) begin nFails++; $display("FAIL zeroa_cnt got=%h exp=0", oCnt); end
    nChecks++; if (obh !== 1'b1) begin nFails++; $display("FAIL zeroa_rng_hold got=%b exp=1", obh); end
  endtask

  task automatic test_unipolar_stream();
    int lat;
    bit obh;
    int exp [4] = '{32, 64, 16, 128};
    iBipolar = 1'b0;
    loadAll(8'd64, 8'd128, 8'd32, 8'd255);
    runWindow(1'b1, 1'b0, lat, obh);
    A = '0;
    nChecks++; if (lat !== 257) begin nFails++; $display("FAIL stream_latency got=%0d exp=257", lat); end
    for (int i = 0; i < NC; i++) begin
      nChecks++;
      if (int'(cntOf(i)) < exp[i] - 1 || int'(cntOf(i)) > exp[i] + 1) begin
        nFails++; $display("FAIL stream ch%0d got=%0d exp=%0d+/-1", i, cntOf(i), exp[i]);
      end
    end
  endtask

  task automatic test_bipolar();
    int lat;
    bit obh;
    logic [CW-1:0] exp0 [4] = '{9'd64, 9'd256, 9'd1, 9'd128};
    logic [CW-1:0] exp1 [4] = '{9'd192, 9'd0, 9'd255, 9'd128};
    iBipolar = 1'b1;
    loadAll(8'd192, 8'd0, 8'd255, 8'd128);
    A = '0;
    runWindow(1'b0, 1'b0, lat, obh);
    for (int i = 0; i < NC; i++) begin
      nChecks++;
      if (cntOf(i) !== exp0[i]) begin nFails++; $display("FAIL bip_a0 ch%0d got=%0d exp=%0d", i, cntOf(i), exp0[i]); end
    end
    A = '1;
    runWindow(1'b0, 1'b0, lat, obh);
    for (int i = 0; i < NC; i++) begin
      nChecks++;
      if (cntOf(i) !== exp1[i]) begin nFails++; $display("FAIL bip_a1 ch%0d got=%0d exp=%0d", i, cntOf(i), exp1[i]); end
    end
    iBipolar = 1'b0;
  endtask

  task automatic test_clear();
    int lat;
    int nValid;
    bit obh;
    // Last completed window was bipolar with A=1.
    logic [NC*CW-1:0] prev = {9'd128, 9'd255, 9'd0, 9'd192};
    logic [CW-1:0] exp [4] = '{9'd10, 9'd20, 9'd30, 9'd40};
    A = '1;
    loadAll(8'd10, 8'd20, 8'd30, 8'd40);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    repeat (100) step();
    iClr = 1'b1;
    step();
    iClr = 1'b0;
    nChecks++; if (oBusy !== 1'b0) begin nFails++; $display("FAIL clr_busy got=%b exp=0", oBusy); end
    nChecks++; if (oCnt !== prev) begin nFails++; $display("FAIL clr_cnt_kept got=%h exp=%h", oCnt, prev); end
    nValid = 0;
    for (int c = 0; c < 300; c++) begin
      if (oValid) nValid++;
      step();
    end
    nChecks++; if (nValid !== 0) begin nFails++; $display("FAIL clr_no_valid got=%0d pulses exp=0", nValid); end
    runWindow(1'b0, 1'b1, lat, obh);
    nChecks++; if (lat !== 257) begin nFails++; $display("FAIL restart_latency got=%0d exp=257", lat); end
    for (int i = 0; i < NC; i++) begin
      nChecks++;
      if (cntOf(i) !== exp[i]) begin nFails++; $display("FAIL restart_loadmid ch%0d got=%0d exp=%0d", i, cntOf(i), exp[i]); end
    end
  endtask

  task automatic test_reset_mid_window();
    int lat;
    bit obh;
    logic [CW-1:0] exp [4] = '{9'd5, 9'd6, 9'd7, 9'd8};
    A = '1;
    loadAll(8'd50, 8'd60, 8'd70, 8'd80);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    repeat (80) step();
    iRstN = 1'b0;
    #2;
    nChecks++; if (oBusy !== 1'b0 || oValid !== 1'b0) begin nFails++; $display("FAIL rstmid_ctrl busy=%b valid=%b exp=0/0", oBusy, oValid); end
    nChecks++; if (oCnt !== '0) begin nFails++; $display("FAIL rstmid_cnt got=%h exp=0", oCnt); end
    step();
    nChecks++; if (oB !== '0 || mult !== '0) begin nFails++; $display("FAIL rstmid_streams oB=%b mult=%b exp=0", oB, mult); end
    iRstN = 1'b1;
    step();
    loadAll(8'd5, 8'd6, 8'd7, 8'd8);
    runWindow(1'b0, 1'b0, lat, obh);
    nChecks++; if (lat !== 257) begin nFails++; $display("FAIL rstmid_latency got=%0d exp=257", lat); end
    for (int i = 0; i < NC; i++) begin
      nChecks++;
      if (cntOf(i) !== exp[i]) begin nFails++; $display("FAIL rstmid_rerun ch%0d got=%0d exp=%0d", i, cntOf(i), exp[i]); end
    end
  endtask

  task automatic test_start_clr_same();
    int nBusy;
    int nValid;
    iStart = 1'b1;
    iClr   = 1'b1;
    step();
    iStart = 1'b0;
    iClr   = 1'b0;
    nBusy  = 0;
    nValid = 0;
    for (int c = 0; c < 20; c++) begin
      if (oBusy) nBusy++;
      if (oValid) nValid++;
      step();
    end
    nChecks++; if (nBusy !== 0) begin nFails++; $display("FAIL startclr_busy got=%0d cycles exp=0", nBusy); end
    nChecks++; if (nValid !== 0) begin nFails++; $display("FAIL startclr_valid got=%0d pulses exp=0", nValid); end
  endtask

  initial begin
    iRstN    = 1'b0;
    iClr     = 1'b0;
    iStart   = 1'b0;
    iBipolar = 1'b0;
    A        = '0;
    B        = '0;
    loadB    = '0;
    test_reset();
    test_unipolar_full();
    test_unipolar_zero_a();
    test_unipolar_stream();
    test_bipolar();
    test_clear();
    test_reset_mid_window();
    test_start_clr_same();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
